mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted transaction waits for mem_resp_valid before an error response.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 ifu_req_valid  input  1  instruction-fetch read request.
REQ-005 ifu_req_addr  input  32  fetch address.
REQ-006 ifu_req_ready  output  1  fetch request accepted this cycle.
REQ-007 ifu_resp_valid  output  1  one-cycle pulse, fetch response.
REQ-008 ifu_resp_data  output  32  fetched word; valid with ifu_resp_valid.
REQ-009 ifu_resp_err  output  1  fetch response is a timeout error.
REQ-010 lsu_req_valid  input  1  load/store request.
REQ-011 lsu_req_wen  input  1  1 = store, 0 = load.
REQ-012 lsu_req_addr  input  32  load/store address.
REQ-013 lsu_req_wdata  input  32  store data.
REQ-014 lsu_req_wmask  input  8  store byte mask.
REQ-015 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-016 lsu_resp_valid  output  1  one-cycle pulse, LSU response.
REQ-017 lsu_resp_data  output  32  load data; 0 for stores and errors.
REQ-018 lsu_resp_err  output  1  LSU response is a timeout error.
REQ-019 mem_valid  output  1  request to shared memory controller.
REQ-020 mem_wen  output  1  write enable to memory controller.
REQ-021 mem_raddr, mem_waddr  output  32 each  read/write address to memory controller.
REQ-022 mem_wdata  output  32; mem_wmask  output  8  write data and mask.
REQ-023 mem_resp_valid  input  1; mem_rdata  input  32  memory completion and read data.

Function
REQ-024 FSM states SHALL be IDLE, BUSY_IFU, BUSY_LSU; one outstanding transaction maximum.
REQ-025 Requests SHALL be accepted only in IDLE; *_req_ready is combinational, asserted only for the winner when its *_req_valid=1 in IDLE.
REQ-026 Arbitration: single requester wins; both valid -> round-robin, winner is the requester not granted last; after reset IFU has priority.
REQ-027 On acceptance, address/wen/wdata/wmask SHALL be latched; IFU requests latch wen=0, wmask=0, wdata=0; FSM moves to BUSY_IFU/BUSY_LSU next cycle.
REQ-028 In BUSY_*: mem_valid=1, mem_raddr=mem_waddr=latched address, other mem_* from latched fields; in IDLE all mem_* outputs SHALL be 0.
REQ-029 Memory request visible the cycle after acceptance (1-cycle issue latency).
REQ-030 mem_resp_valid=1 in BUSY_* SHALL register response: owner's *_resp_valid pulses exactly one cycle next cycle, resp_data = mem_rdata (load/fetch) or 0 (store), resp_err=0; FSM returns to IDLE the same edge.
REQ-031 mem_resp_valid in IDLE SHALL be ignored.
REQ-032 Cycle counter SHALL clear on acceptance and increment each BUSY_* cycle without mem_resp_valid; on reaching TIMEOUT: error response (resp_valid=1, resp_err=1, resp_data=0) to owner, return to IDLE.
REQ-033 mem_resp_valid on the same cycle as timeout SHALL win: normal response, no error.
REQ-034 New request SHALL be acceptable in the cycle the response pulse is driven (FSM already IDLE); accepted addresses/data SHALL not change while BUSY even if request inputs change.

Reset
REQ-035 rst=1 SHALL immediately force IDLE, counter 0, round-robin pointer to IFU-priority, all outputs 0.
REQ-036 Reset mid-transaction SHALL drop it silently: no response pulse after reset release; late mem_resp_valid ignored.

Verification
REQ-037 IFU only: ifu addr 0x8000_0000, mem_rdata 0x0000_0413 after 3 cycles -> mem_valid cycle+1, ifu_resp_valid one pulse with 0x0000_0413, err=0.
REQ-038 Simultaneous requests twice after reset -> IFU granted first, then LSU; third simultaneous pair -> IFU again.
REQ-039 LSU store addr 0x8000_0010, wdata 0xDEADBEEF, wmask 0x0F -> mem_wen=1 with these values, lsu_resp_data=0, err=0.
REQ-040 No mem_resp_valid, TIMEOUT=4 -> error pulse after 4 BUSY cycles, resp_data=0, err=1; IDLE; mem_resp_valid on timeout cycle -> normal response.
REQ-041 rst asserted while BUSY_LSU -> outputs 0 asynchronously; later mem_resp_valid produces no lsu_resp_valid.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / load-store) arbiter in front of a single-outstanding memory port.
// Round-robin on contention, registered responses and a per-transaction timeout.
module mem_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  input  logic [31:0] ifu_req_addr,
  output logic        ifu_req_ready,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_resp_data,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  input  logic        lsu_req_wen,
  input  logic [31:0] lsu_req_addr,
  input  logic [31:0] lsu_req_wdata,
  input  logic [7:0]  lsu_req_wmask,
  output logic        lsu_req_ready,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_resp_data,
  output logic        lsu_resp_err,
  output logic        mem_valid,
  output logic        mem_wen,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StBusyIfu, StBusyLsu} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              prio_lsu_q, prio_lsu_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [7:0]        wmask_q, wmask_d;
  logic              wen_q, wen_d;
  logic              ifu_rv_q, ifu_rv_d;
  logic              lsu_rv_q, lsu_rv_d;
  logic [31:0]       data_q, data_d;
  logic              err_q, err_d;

  logic grant_ifu, grant_lsu, busy;

  // prio_lsu_q set means IFU was granted last, so LSU wins a tie.
  assign grant_ifu = ifu_req_valid & (~lsu_req_valid | ~prio_lsu_q);
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | prio_lsu_q);
  assign busy      = (state_q != StIdle);

  // Gated by rst so every output is low while reset is held.
  assign ifu_req_ready = (state_q == StIdle) & ~rst & grant_ifu;
  assign lsu_req_ready = (state_q == StIdle) & ~rst & grant_lsu;

  assign mem_valid = busy;
  assign mem_wen   = busy & wen_q;
  assign mem_raddr = busy ? addr_q : '0;
  assign mem_waddr = busy ? addr_q : '0;
  assign mem_wdata = busy ? wdata_q : '0;
  assign mem_wmask = busy ? wmask_q : '0;

  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_data  = ifu_rv_q ? data_q : '0;
  assign ifu_resp_err   = ifu_rv_q & err_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_data  = lsu_rv_q ? data_q : '0;
  assign lsu_resp_err   = lsu_rv_q & err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_lsu_d = prio_lsu_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    wen_d      = wen_q;
    ifu_rv_d   = 1'b0;
    lsu_rv_d   = 1'b0;
    data_d     = '0;
    err_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ifu_req_ready) begin
          state_d    = StBusyIfu;
          cnt_d      = '0;
          prio_lsu_d = 1'b1;
          addr_d     = ifu_req_addr;
          wen_d      = 1'b0;
          wdata_d    = '0;
          wmask_d    = '0;
        end else if (lsu_req_ready) begin
          state_d    = StBusyLsu;
          cnt_d      = '0;
          prio_lsu_d = 1'b0;
          addr_d     = lsu_req_addr;
          wen_d      = lsu_req_wen;
          wdata_d    = lsu_req_wdata;
          wmask_d    = lsu_req_wmask;
        end
      end
      StBusyIfu, StBusyLsu: begin
        // A completion arriving on the timeout cycle takes precedence.
        if (mem_resp_valid || cnt_q == CntW'(TIMEOUT - 1)) begin
          state_d  = StIdle;
          ifu_rv_d = (state_q == StBusyIfu);
          lsu_rv_d = (state_q == StBusyLsu);
          err_d    = ~mem_resp_valid;
          data_d   = (mem_resp_valid && !wen_q) ? mem_rdata : '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prio_lsu_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      wen_q      <= 1'b0;
      ifu_rv_q   <= 1'b0;
      lsu_rv_q   <= 1'b0;
      data_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prio_lsu_q <= prio_lsu_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      wen_q      <= wen_d;
      ifu_rv_q   <= ifu_rv_d;
      lsu_rv_q   <= lsu_rv_d;
      data_q     <= data_d;
      err_q      <= err_d;
    end
  end

endmodule
